// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 8;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; tc_o flags the last allowed wait cycle.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16,
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            logic unused_s;
            assign unused_s = ^{clk_i, rst_ni, clr_i, en_i};
            assign tc_o     = 1'b0;
        end else begin : g_timeout
            localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);
            logic [CNT_W-1:0] cnt_q;

            // Wait counter, saturating at the terminal value.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= '0;
                end else if (en_i && (cnt_q != TC_VAL)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else begin
                    cnt_q <= cnt_q;
                end
            end

            assign tc_o = (cnt_q == TC_VAL);
        end
    endgenerate

endmodule

// File: rtl/apb_m.sv
// APB requester: single-beat commands in, SETUP/ACCESS sequencing out,
// one-cycle response pulse with read data or timeout error.
module apb_m
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              req_ready_q, req_ready_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              tc_s;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .clr_i  (cnt_clr_s),
        .en_i   (cnt_en_s),
        .tc_o   (tc_s)
    );

    // Next-state, bus-attribute capture and response generation.
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    cnt_clr_s = 1'b1;
                    state_d   = SETUP;
                end else begin
                    state_d   = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over the timeout on the terminal cycle.
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else if (tc_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_en_s    = 1'b1;
                    state_d     = ACCESS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake/phase flags come from the next state so they are flops, not decode.
    always_comb begin
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        req_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset drops any in-flight transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_ready_q <= req_ready_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_m.sv
// Bench for apb_m: behavioural 16x8 APB slave plus a memory reference model,
// directed scenarios followed by randomized transfers.
module tb_apb_m;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [16];
    logic [7:0] slv_mem [16];
    logic [7:0] last_rdata;
    logic       last_err;

    apb_m #(
        .ADDR_W  (4),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transfer, entered and left on a negedge; ends in the response cycle.
    // stub: slave never asserts pready. waits: ACCESS cycles before pready.
    // hold: keep req_valid asserted so the same command is re-presented.
    task automatic xfer(input bit w, input logic [3:0] a, input logic [7:0] d,
                        input bit stub, input int waits, input bit hold);
        int         acc;
        int         exp_acc;
        logic [3:0] pa;
        logic [7:0] pw;
        logic [7:0] exp_rd;
        logic       exp_err;

        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        chk("req_ready_idle", req_ready, 1);
        @(negedge pclk);

        chk("setup_phase", {psel, penable, req_ready}, 3'b100);
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_rdata_hold", rsp_rdata, last_rdata);
        chk("rsp_err_hold", rsp_err, last_err);
        chk("paddr", paddr, a);
        chk("pwrite", pwrite, w);
        if (w) chk("pwdata", pwdata, d);
        pa = paddr;
        pw = pwdata;
        if (!hold) begin
            req_valid = 1'b0;
            req_addr  = 4'($urandom);
            req_wdata = 8'($urandom);
            req_write = 1'($urandom);
        end
        pready = 1'($urandom_range(0, 1));
        prdata = 8'($urandom);
        @(negedge pclk);

        acc = 0;
        while (penable === 1'b1 && acc < 40) begin
            chk("access_phase", {psel, penable, req_ready}, 3'b110);
            chk("paddr_stable", paddr, pa);
            chk("pwdata_stable", pwdata, pw);
            if (!stub && acc >= waits) begin
                pready = 1'b1;
                prdata = slv_mem[pa];
            end else begin
                pready = 1'b0;
                prdata = 8'($urandom);
            end
            acc++;
            @(negedge pclk);
            if (pready && pwrite) slv_mem[pa] = pw;
        end
        pready = 1'b0;

        exp_acc = stub ? 16 : waits + 1;
        exp_err = stub;
        exp_rd  = (stub || w) ? 8'h00 : ref_mem[a];
        if (w && !stub) ref_mem[a] = d;
        chk("access_cycles", acc, exp_acc);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_cycle_idle", {psel, penable, req_ready}, 3'b001);
        last_rdata = exp_rd;
        last_err   = exp_err;
    endtask

    initial begin
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        pready    = 1'b0;
        prdata    = 8'h00;
        last_rdata = 8'h00;
        last_err   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'h00;
            slv_mem[i] = 8'h00;
        end

        repeat (3) @(negedge pclk);
        chk("reset_outputs", {psel, penable, req_ready, rsp_valid, rsp_err,
                              rsp_rdata, paddr, pwdata, pwrite}, 0);
        presetn = 1'b1;
        #1;
        chk("ready_before_edge", req_ready, 0);
        @(negedge pclk);
        chk("ready_after_reset", req_ready, 1);

        // Basic write then read-back.
        xfer(1'b1, 4'h5, 8'hA7, 1'b0, 0, 1'b0);
        xfer(1'b0, 4'h5, 8'h00, 1'b0, 0, 1'b0);

        // Held req_valid: re-presented command accepted straight after the response.
        xfer(1'b1, 4'h9, 8'h33, 1'b0, 1, 1'b1);
        xfer(1'b1, 4'h9, 8'h33, 1'b0, 0, 1'b0);

        // Timeout abort, then pready on the terminal wait cycle.
        xfer(1'b0, 4'h9, 8'h00, 1'b1, 0, 1'b0);
        xfer(1'b1, 4'h2, 8'h5C, 1'b1, 0, 1'b0);
        xfer(1'b0, 4'h9, 8'h00, 1'b0, 15, 1'b0);
        xfer(1'b0, 4'h2, 8'h00, 1'b0, 0, 1'b0);

        // Fill and read back the whole slave.
        for (int i = 0; i < 16; i++) xfer(1'b1, 4'(i), 8'(8'h10 + i), 1'b0, i % 3, 1'b0);
        for (int i = 0; i < 16; i++) xfer(1'b0, 4'(i), 8'h00, 1'b0, (i + 1) % 3, 1'b0);

        // Asynchronous reset in the middle of an ACCESS phase.
        @(negedge pclk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'h3;
        req_wdata = 8'h3C;
        @(negedge pclk);
        req_valid = 1'b0;
        pready    = 1'b0;
        @(negedge pclk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        #2;
        presetn = 1'b0;
        #1;
        chk("async_reset_outputs", {psel, penable, rsp_valid, req_ready}, 4'b0000);
        chk("async_reset_paddr", paddr, 0);
        @(negedge pclk);
        presetn    = 1'b1;
        last_rdata = 8'h00;
        last_err   = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            chk("no_rsp_after_reset", {rsp_valid, psel}, 2'b00);
        end
        xfer(1'b0, 4'h3, 8'h00, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            bit         w;
            bit         stub;
            bit         hold;
            logic [3:0] a;
            logic [7:0] d;
            w    = 1'($urandom_range(0, 1));
            a    = 4'($urandom);
            d    = 8'($urandom);
            stub = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 7) == 0);
            xfer(w, a, d, stub, int'($urandom_range(0, 3)), hold);
            if (hold) begin
                xfer(w, a, d, 1'b0, 0, 1'b0);
            end
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        @(negedge pclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
